// File: rtl/dmem_if.sv
// Request/response bus between a load/store unit and the data memory controller.
`timescale 1ns/1ps
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I data memory controller: one outstanding request, fixed latency,
// byte-lane memory with fault detection and a saturating fault counter.
`timescale 1ns/1ps
module dmem_ctrl #(
  parameter int DEPTH_BYTES = 4096,
  parameter int LATENCY     = 2,
  parameter int ERRCNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  dmem_if.slave               bus,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  logic [1:0]  state_reg;
  logic [2:0]  cnt_reg;
  logic        run_reg;
  logic        write_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        err_reg;

  logic        accept;
  logic        go_resp;
  logic        cur_write;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  size_m1;
  logic        legal;
  logic        misalign;
  logic [32:0] last_byte;
  logic        fault;
  logic [AW-3:0] word_idx;
  logic [7:0]  rd_byte [4];
  logic [31:0] rd_word;

  // Ready only once out of reset so nothing is accepted while rst is high.
  assign bus.req_ready = (state_reg == ST_IDLE) && run_reg;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (state_reg == ST_RESP);
  assign bus.rsp_err   = err_reg;

  // The memory access happens on the edge that enters RESP.
  assign go_resp = (accept && (LATENCY == 1)) ||
                   ((state_reg == ST_WAIT) && (cnt_reg == 3'd0));

  // With LATENCY==1 the access uses the live request, otherwise the latched one.
  always_comb begin
    cur_write  = write_reg;
    cur_funct3 = funct3_reg;
    cur_addr   = addr_reg;
    cur_wdata  = wdata_reg;
    if (state_reg == ST_IDLE) begin
      cur_write  = bus.req_write;
      cur_funct3 = bus.req_funct3;
      cur_addr   = bus.req_addr;
      cur_wdata  = bus.req_wdata;
    end
  end

  // Fault classification: illegal funct3, misalignment, or past end of memory.
  always_comb begin
    size_m1 = 2'd0;
    case (cur_funct3[1:0])
      2'b01:   size_m1 = 2'd1;
      2'b10:   size_m1 = 2'd3;
      default: size_m1 = 2'd0;
    endcase
    if (cur_write)
      legal = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010);
    else
      legal = (cur_funct3 != 3'b011) && (cur_funct3 != 3'b110) && (cur_funct3 != 3'b111);
    misalign  = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    last_byte = {1'b0, cur_addr} + {31'b0, size_m1};
    fault     = !legal || misalign || (last_byte >= 33'(DEPTH_BYTES));
  end

  assign word_idx = cur_addr[AW-1:2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [WORDS] = '{default: 8'h00};
      logic [7:0] rd_reg;
      logic       be;
      logic [7:0] wd;

      // Lane enable and data for SB/SH/SW, little-endian.
      always_comb begin
        be = 1'b0;
        wd = cur_wdata[8*gi +: 8];
        case (cur_funct3[1:0])
          2'b00: begin
            be = (cur_addr[1:0] == 2'(gi));
            wd = cur_wdata[7:0];
          end
          2'b01: begin
            be = (cur_addr[1] == 1'(gi / 2));
            wd = cur_wdata[8*(gi % 2) +: 8];
          end
          default: be = 1'b1;
        endcase
      end

      // Byte lane storage with registered read; not touched by reset.
      always_ff @(posedge clk) begin
        if (go_resp) begin
          if (cur_write && !fault && be)
            mem[word_idx] <= wd;
          rd_reg <= mem[word_idx];
        end
      end

      assign rd_byte[gi] = rd_reg;
    end
  endgenerate

  assign rd_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

  // Load alignment and extension; zero for stores, faults and outside RESP.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rd_word[{addr_reg[1:0], 3'b000} +: 8];
    h = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
    bus.rsp_rdata = 32'h0;
    if ((state_reg == ST_RESP) && !write_reg && !err_reg) begin
      case (funct3_reg)
        3'b000:  bus.rsp_rdata = {{24{b[7]}}, b};
        3'b100:  bus.rsp_rdata = {24'h0, b};
        3'b001:  bus.rsp_rdata = {{16{h[15]}}, h};
        3'b101:  bus.rsp_rdata = {16'h0, h};
        3'b010:  bus.rsp_rdata = rd_word;
        default: bus.rsp_rdata = 32'h0;
      endcase
    end
  end

  // Control FSM, request latch, response status and fault counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 3'd0;
      run_reg    <= 1'b0;
      write_reg  <= 1'b0;
      funct3_reg <= 3'd0;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      err_reg    <= 1'b0;
      err_count  <= '0;
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            write_reg  <= bus.req_write;
            funct3_reg <= bus.req_funct3;
            addr_reg   <= bus.req_addr;
            wdata_reg  <= bus.req_wdata;
            cnt_reg    <= CNT_INIT;
            state_reg  <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 3'd0) state_reg <= ST_RESP;
          else                 cnt_reg   <= cnt_reg - 3'd1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (go_resp) begin
        err_reg <= fault;
        if (fault && (err_count != {ERRCNT_W{1'b1}}))
          err_count <= err_count + {{(ERRCNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table on a LATENCY=2 instance plus
// hand-written stall, reset, latency-sweep and counter-saturation sequences.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        req_valid, req_write, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;
  logic [15:0] cur_ec;

  logic [15:0] ec0, ec3;
  logic [3:0]  ec1;
  logic [15:0] ec2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_if bus0 ();
  dmem_if bus1 ();
  dmem_if bus2 ();
  dmem_if bus3 ();

  dmem_ctrl #(.DEPTH_BYTES(4096), .LATENCY(2), .ERRCNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .err_count(ec0));
  dmem_ctrl #(.DEPTH_BYTES(4096), .LATENCY(4), .ERRCNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1), .err_count(ec1));
  dmem_ctrl #(.DEPTH_BYTES(4096), .LATENCY(1), .ERRCNT_W(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .err_count(ec2));
  dmem_ctrl #(.DEPTH_BYTES(4096), .LATENCY(8), .ERRCNT_W(16)) dut3 (.clk(clk), .rst(rst), .bus(bus3), .err_count(ec3));

  assign bus0.req_valid = req_valid && (sel == 2'd0);
  assign bus1.req_valid = req_valid && (sel == 2'd1);
  assign bus2.req_valid = req_valid && (sel == 2'd2);
  assign bus3.req_valid = req_valid && (sel == 2'd3);
  assign bus0.rsp_ready = rsp_ready && (sel == 2'd0);
  assign bus1.rsp_ready = rsp_ready && (sel == 2'd1);
  assign bus2.rsp_ready = rsp_ready && (sel == 2'd2);
  assign bus3.rsp_ready = rsp_ready && (sel == 2'd3);
  assign bus0.req_write = req_write;  assign bus0.req_funct3 = req_funct3;
  assign bus0.req_addr  = req_addr;   assign bus0.req_wdata  = req_wdata;
  assign bus1.req_write = req_write;  assign bus1.req_funct3 = req_funct3;
  assign bus1.req_addr  = req_addr;   assign bus1.req_wdata  = req_wdata;
  assign bus2.req_write = req_write;  assign bus2.req_funct3 = req_funct3;
  assign bus2.req_addr  = req_addr;   assign bus2.req_wdata  = req_wdata;
  assign bus3.req_write = req_write;  assign bus3.req_funct3 = req_funct3;
  assign bus3.req_addr  = req_addr;   assign bus3.req_wdata  = req_wdata;

  // Observe the selected instance.
  always_comb begin
    cur_ready = bus0.req_ready; cur_valid = bus0.rsp_valid;
    cur_err   = bus0.rsp_err;   cur_rdata = bus0.rsp_rdata; cur_ec = ec0;
    case (sel)
      2'd1: begin cur_ready = bus1.req_ready; cur_valid = bus1.rsp_valid;
                  cur_err = bus1.rsp_err; cur_rdata = bus1.rsp_rdata; cur_ec = {12'h0, ec1}; end
      2'd2: begin cur_ready = bus2.req_ready; cur_valid = bus2.rsp_valid;
                  cur_err = bus2.rsp_err; cur_rdata = bus2.rsp_rdata; cur_ec = ec2; end
      2'd3: begin cur_ready = bus3.req_ready; cur_valid = bus3.rsp_valid;
                  cur_err = bus3.rsp_err; cur_rdata = bus3.rsp_rdata; cur_ec = ec3; end
      default: ;
    endcase
  end

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
    logic [15:0] ec;
  } vec_t;

  vec_t tv [40];
  int   nv = 0;

  task automatic add(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] rd, input logic er, input logic [15:0] ec);
    tv[nv] = '{w, f3, a, d, rd, er, ec};
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction on the selected instance; returns data, error flag
  // and observed latency (accept edge to first rsp_valid, in cycles).
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check("ready_before", 32'(cur_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!cur_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = cur_rdata;
    er = cur_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("ready_after", 32'(cur_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wt;

    rst = 1'b1; sel = 2'd0; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(cur_valid), 32'd0);
    check("rst_rsp_rdata", cur_rdata, 32'd0);
    check("rst_rsp_err",   32'(cur_err), 32'd0);
    check("rst_err_count", 32'(cur_ec), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(cur_ready), 32'd1);

    // Vector table for the LATENCY=2 / DEPTH 4096 instance.
    add(1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        0, 0);
    add(0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 0, 0);
    add(0, 3'b000, 32'h13,       32'h0,        32'hFFFFFFDE, 0, 0);
    add(0, 3'b100, 32'h13,       32'h0,        32'h000000DE, 0, 0);
    add(0, 3'b001, 32'h12,       32'h0,        32'hFFFFDEAD, 0, 0);
    add(0, 3'b101, 32'h10,       32'h0,        32'h0000BEEF, 0, 0);
    add(1, 3'b001, 32'h11,       32'h1234,     32'h0,        1, 1);
    add(0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 0, 1);
    add(0, 3'b010, 32'hFFE,      32'h0,        32'h0,        1, 2);
    add(0, 3'b010, 32'hFFC,      32'h0,        32'h0,        0, 2);
    add(0, 3'b001, 32'hFFE,      32'h0,        32'h0,        0, 2);
    add(0, 3'b000, 32'h1000,     32'h0,        32'h0,        1, 3);
    add(1, 3'b000, 32'h11,       32'h77,       32'h0,        0, 3);
    add(0, 3'b010, 32'h10,       32'h0,        32'hDEAD77EF, 0, 3);
    add(1, 3'b001, 32'h12,       32'hCAFE,     32'h0,        0, 3);
    add(0, 3'b010, 32'h10,       32'h0,        32'hCAFE77EF, 0, 3);
    add(0, 3'b011, 32'h0,        32'h0,        32'h0,        1, 4);
    add(1, 3'b100, 32'h20,       32'hFFFFFFFF, 32'h0,        1, 5);
    add(0, 3'b010, 32'h20,       32'h0,        32'h0,        0, 5);
    add(0, 3'b000, 32'h10,       32'h0,        32'hFFFFFFEF, 0, 5);
    add(0, 3'b100, 32'h11,       32'h0,        32'h00000077, 0, 5);
    add(0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        1, 6);
    add(1, 3'b010, 32'hFFC,      32'h8899AABB, 32'h0,        0, 6);
    add(0, 3'b101, 32'hFFE,      32'h0,        32'h00008899, 0, 6);
    add(0, 3'b001, 32'hFFE,      32'h0,        32'hFFFF8899, 0, 6);
    add(0, 3'b100, 32'hFFF,      32'h0,        32'h00000088, 0, 6);
    add(1, 3'b101, 32'h10,       32'h55555555, 32'h0,        1, 7);
    add(0, 3'b010, 32'h10,       32'h0,        32'hCAFE77EF, 0, 7);

    sel = 2'd0;
    for (int i = 0; i < nv; i++) begin
      do_req(tv[i].w, tv[i].f3, tv[i].a, tv[i].d, rd, er, lat);
      $display("vec %0d: w=%0d f3=%03b addr=%08h rdata=%08h err=%0d cnt=%0d lat=%0d",
               i, tv[i].w, tv[i].f3, tv[i].a, rd, er, cur_ec, lat);
      check($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].er));
      check($sformatf("vec%0d_errcnt", i), 32'(cur_ec), 32'(tv[i].ec));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Back-pressure: response held stable while rsp_ready stays low.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wt = 0;
    while (!cur_valid && wt < 20) begin @(negedge clk); wt++; end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(cur_valid), 32'd1);
      check("stall_rdata", cur_rdata, 32'hCAFE77EF);
      check("stall_err",   32'(cur_err), 32'd0);
      check("stall_ready", 32'(cur_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stall_ready_after", 32'(cur_ready), 32'd1);
    $display("stall: LW 0x10 held 5 cycles, released");

    // A store committed in RESP survives a reset that hits before the handshake.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wt = 0;
    while (!cur_valid && wt < 20) begin @(negedge clk); wt++; end
    check("persist_valid", 32'(cur_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("persist_rst_valid", 32'(cur_valid), 32'd0);
    check("persist_rst_errcnt", 32'(cur_ec), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    $display("persist: LW 0x40 rdata=%08h err=%0d", rd, er);
    check("persist_rdata", rd, 32'h11223344);

    // Reset during WAIT aborts a store (LATENCY=4 instance).
    sel = 2'd1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_rsp_valid", 32'(cur_valid), 32'd0);
      check("abort_errcnt", 32'(cur_ec), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(cur_valid), 32'd0);
    end
    check("abort_ready", 32'(cur_ready), 32'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    $display("abort: LW 0x20 rdata=%08h err=%0d lat=%0d", rd, er, lat);
    check("abort_rdata", rd, 32'h0);
    check("abort_err", 32'(er), 32'd0);
    check("abort_latency", 32'(lat), 32'd4);

    // Latency sweep at the extremes.
    sel = 2'd2;
    do_req(1'b1, 3'b010, 32'h8, 32'h01020304, rd, er, lat);
    check("lat1_sw_latency", 32'(lat), 32'd1);
    do_req(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat);
    $display("lat1: LW 0x8 rdata=%08h lat=%0d", rd, lat);
    check("lat1_lw_latency", 32'(lat), 32'd1);
    check("lat1_lw_rdata", rd, 32'h01020304);
    sel = 2'd3;
    do_req(1'b1, 3'b010, 32'h8, 32'h0A0B0C0D, rd, er, lat);
    check("lat8_sw_latency", 32'(lat), 32'd8);
    do_req(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat);
    $display("lat8: LW 0x8 rdata=%08h lat=%0d", rd, lat);
    check("lat8_lw_latency", 32'(lat), 32'd8);
    check("lat8_lw_rdata", rd, 32'h0A0B0C0D);

    // 4-bit fault counter saturates at 15 after 17 faults.
    sel = 2'd1;
    for (int i = 1; i <= 17; i++) begin
      do_req(1'b0, 3'b010, 32'h1, 32'h0, rd, er, lat);
      $display("sat %0d: err=%0d cnt=%0d", i, er, cur_ec);
      check($sformatf("sat%0d_err", i), 32'(er), 32'd1);
      check($sformatf("sat%0d_errcnt", i), 32'(cur_ec), (i > 15) ? 32'd15 : 32'(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 4096: byte-addressable storage size; power of two, range 16..65536.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response valid; range 1..8.
REQ-003 SHALL have parameter ERRCNT_W, default 16: width of the error counter.
REQ-004 SHALL have port clk  in  1: clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  1: request present.
REQ-007 SHALL have port req_ready  out  1: block can accept a request.
REQ-008 SHALL have port req_write  in  1: 1 = store, 0 = load.
REQ-009 SHALL have port req_funct3  in  3: RV32I load/store funct3 (width and signedness).
REQ-010 SHALL have port req_addr  in  32: byte address.
REQ-011 SHALL have port req_wdata  in  32: store data, LSB-aligned.
REQ-012 SHALL have port rsp_valid  out  1: response present.
REQ-013 SHALL have port rsp_ready  in  1: consumer accepts the response.
REQ-014 SHALL have port rsp_rdata  out  32: load result, sign/zero extended.
REQ-015 SHALL have port rsp_err  out  1: request faulted.
REQ-016 SHALL have port err_count  out  ERRCNT_W: saturating count of faulted requests.

Function
REQ-017 SHALL implement FSM IDLE, WAIT, RESP, with at most one request outstanding.
REQ-018 SHALL drive req_ready=1 only in IDLE; acceptance is req_valid&req_ready at a rising edge, latching write, funct3, addr and wdata.
REQ-019 On accept, SHALL go to RESP if LATENCY==1, else to WAIT with the down-counter loaded to LATENCY-2.
REQ-020 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0; rsp_valid first rises exactly LATENCY cycles after the accept edge.
REQ-021 SHALL perform the memory read or write on the edge entering RESP, never earlier.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid&rsp_ready, then return to IDLE; there is no back-to-back accept, so req_ready rises the cycle after the handshake.
REQ-023 Loads: funct3 010=LW, 001=LH (sign-ext), 101=LHU (zero-ext), 000=LB (sign-ext), 100=LBU (zero-ext); little-endian byte order.
REQ-024 Stores: funct3 000=SB, 001=SH, 010=SW; only the addressed bytes are modified.
REQ-025 Store responses SHALL return rsp_rdata=0.
REQ-026 Fault conditions: illegal funct3 (load 011/110/111, store 011..111); misalignment (half-word with addr[0]=1, word with addr[1:0]!=0); out of range (addr+size-1 >= DEPTH_BYTES, 32-bit compare, no wrap).
REQ-027 On a fault, SHALL leave memory unmodified, set rsp_rdata=0 and rsp_err=1, and keep the same latency as a good access.
REQ-028 err_count SHALL increment by 1 on the edge entering RESP with a fault, saturating at all-ones.
REQ-029 Memory contents SHALL initialise to 0 at simulation start.

Reset
REQ-030 While rst=1: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0; req_ready=1 after rst deasserts.
REQ-031 Reset during WAIT SHALL abort the request with no memory write and no response.
REQ-032 Reset SHALL NOT clear memory contents; a store already committed in RESP persists.

Verification
REQ-033 LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 2 cycles after each accept, load rdata=0xDEADBEEF, rsp_err=0.
REQ-034 After REQ-033: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-035 SH addr 0x11 data 0x1234 -> rsp_err=1, err_count=1, subsequent LW 0x10 still returns 0xDEADBEEF; LW 0x0FFE (DEPTH 4096) -> rsp_err=1, err_count=2.
REQ-036 Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout; req_ready=1 one cycle after the handshake.
REQ-037 Assert rst one cycle after accepting SW 0x20 data 0xA5A5A5A5 (LATENCY=4) -> no response, err_count=0, LW 0x20 after reset returns 0x00000000.
REQ-038 Sweep LATENCY=1 and 8 -> rsp_valid rises exactly LATENCY cycles after accept; force 2^ERRCNT_W+1 faults with ERRCNT_W=4 -> err_count saturates at 15.
